systolic_skew_feeder: RTL and testbench

//  Upstream operand feeder for one edge of the systolic PE array.
//  - Buffers N-lane FP32 operand beats arriving over a valid/ready stream.
//  - Re-emits them with triangular skew: lane i is delayed i advances, so operands

---
 rtl/systolic_skew_feeder.sv | 179 +++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for one systolic-array edge: FIFO-buffered N-lane beats re-emitted with
// triangular lane skew plus zero drain. Optional stall counter under SKEW_FEEDER_STATS_EN.
module systolic_skew_feeder #(
  parameter int N     = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  output logic            out_valid,
  output logic [N*DW-1:0] out_data,
  output logic            busy,
  output logic            done
`ifdef SKEW_FEEDER_STATS_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state_reg;
  logic [N*DW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            in_ready_reg;
  logic [15:0]     k_len_reg;
  logic [15:0]     beat_cnt_reg;
  logic [DCW-1:0]  drain_cnt_reg;
  logic            done_pend_reg;
  logic            done_reg;
  logic            out_valid_reg;

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            advance;
  logic [N*DW-1:0] head_data;

  assign push       = in_valid && in_ready_reg;
  assign fifo_empty = (count_reg == '0);
  assign pop        = (state_reg == STREAM) && !fifo_empty;
  assign advance    = pop || (state_reg == DRAIN);
  // Drain cycles inject zero beats so the chains empty cleanly behind the tile.
  assign head_data  = pop ? fifo_mem[rd_ptr_reg] : '0;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg    <= count_next;
      in_ready_reg <= (count_next != CW'(DEPTH));
    end
  end

  // done is deferred one cycle so it follows the final out_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      k_len_reg     <= '0;
      beat_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      done_pend_reg <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      done_reg      <= done_pend_reg;
      done_pend_reg <= 1'b0;
      out_valid_reg <= advance;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (k_len != 16'd0) begin
              k_len_reg    <= k_len;
              beat_cnt_reg <= '0;
              state_reg    <= STREAM;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (pop) begin
            beat_cnt_reg <= beat_cnt_reg + 16'd1;
            if (beat_cnt_reg == k_len_reg - 16'd1) begin
              drain_cnt_reg <= '0;
              state_reg     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          drain_cnt_reg <= drain_cnt_reg + DCW'(1);
          if (drain_cnt_reg == DCW'(N - 2)) begin
            state_reg     <= IDLE;
            done_pend_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DW-1:0] lane_reg;
    if (gi == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (advance) begin
          lane_reg <= head_data[0 +: DW];
        end
      end
    end else begin : g_chain
      // Packed delay line: newest beat at the bottom, oldest (beat t-gi) at the top.
      logic [gi*DW-1:0] stage_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg  <= '0;
          stage_reg <= '0;
        end else if (advance) begin
          lane_reg  <= stage_reg[gi*DW-1 -: DW];
          stage_reg <= (gi*DW)'({stage_reg, head_data[gi*DW +: DW]});
        end
      end
    end
    assign out_data[gi*DW +: DW] = lane_reg;
  end

`ifdef SKEW_FEEDER_STATS_EN
  logic [31:0] stall_cnt_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == STREAM && fifo_empty && stall_cnt_reg != 32'hFFFF_FFFF) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end
  assign stall_cnt = stall_cnt_reg;
`endif

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: expected skewed vectors are derived per tile
// from the beat list and checked by an independent out_valid monitor.
module tb_systolic_skew_feeder;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int VW    = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   k_len = '0;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [VW-1:0] out_data;
  logic          busy;
  logic          done;
`ifdef SKEW_FEEDER_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int last_ov_cyc = -10;
  logic [VW-1:0] exp_q[$];

  systolic_skew_feeder #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
`ifdef SKEW_FEEDER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every advance strobe consumes one expected vector.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      ov_cnt++;
      last_ov_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got data %h, required no pulse (cycle %0d)", out_data, cyc);
      end else begin
        chk("lane_data", out_data, exp_q.pop_front());
      end
    end
  end

  // Reference: pulse t carries lane i of beat t-i when that beat exists, else zero.
  task automatic push_expected(input logic [VW-1:0] bq[$]);
    int k;
    logic [VW-1:0] v;
    k = bq.size();
    for (int t = 0; t < k + N - 1; t++) begin
      v = '0;
      for (int i = 0; i < N; i++)
        if (t - i >= 0 && t - i < k) v[i*DW +: DW] = bq[t-i][i*DW +: DW];
      exp_q.push_back(v);
    end
  endtask

  task automatic feed_beat(input logic [VW-1:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("feed_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic issue_start(input int k);
    @(negedge clk);
    start = 1'b1;
    k_len = 16'(k);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_tile(input int k, input int base);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      #1 guard++;
    end while (done !== 1'b1 && guard < 400);
    chk("done_seen", done, 1'b1);
    chk("done_after_last_pulse", cyc, last_ov_cyc + 1);
    chk("pulse_count", ov_cnt - base, k + N - 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    #1;
    chk("done_single_cycle", done, 1'b0);
    chk("idle_after_tile", busy, 1'b0);
  endtask

  task automatic run_tile(input logic [VW-1:0] bq[$], input int p, input int gap, input bit poke);
    int k;
    int base;
    k = bq.size();
    base = ov_cnt;
    push_expected(bq);
    for (int b = 0; b < p; b++) feed_beat(bq[b]);
    issue_start(k);
    @(negedge clk);
    #1 chk("busy_after_start", busy, 1'b1);
    if (poke) begin
      // A start while busy must not disturb the latched length.
      start = 1'b1;
      k_len = 16'(k + 3);
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int b = p; b < k; b++) begin
      feed_beat(bq[b]);
      repeat (gap) @(negedge clk);
    end
    finish_tile(k, base);
  endtask

  function automatic logic [VW-1:0] rand_beat();
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] bq[$];
    int base;
    int guard;
    int k;
    int p;

    // Reset held with in_valid high.
    in_valid = 1'b1;
    in_data  = {N{32'hDEADBEEF}};
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("in_ready_after_rst", in_ready, 1'b1);

    // Preloaded 3-beat tile.
    bq = '{ {N{32'h40000000}}, {N{32'h40800000}}, {N{32'h41000000}} };
    run_tile(bq, 3, 0, 1'b0);

    // Overfill while idle: 8 of 9 accepted, space returns after the first pop.
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(rand_beat());
    base = ov_cnt;
    push_expected(bq);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (i < 8) ? bq[i] : rand_beat();
      #1 chk("in_ready_fill", in_ready, (i < 8));
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    issue_start(8);
    @(negedge clk);
    #1;
    chk("in_ready_full_first_stream", in_ready, 1'b0);
    chk("busy_full_start", busy, 1'b1);
    @(negedge clk);
    #1 chk("in_ready_after_pop", in_ready, 1'b1);
    finish_tile(8, base);

    // Empty FIFO at start, one beat every 3 cycles.
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(rand_beat());
    run_tile(bq, 0, 2, 1'b0);

    // Zero-length tile.
    base = ov_cnt;
    issue_start(0);
    @(negedge clk);
    #1;
    chk("k0_done", done, 1'b1);
    chk("k0_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("k0_no_pulses", ov_cnt - base, 0);
    chk("k0_done_cleared", done, 1'b0);

    // Randomized tiles.
    for (int r = 0; r < 12; r++) begin
      k = $urandom_range(1, 12);
      p = $urandom_range(0, (k < DEPTH) ? k : DEPTH);
      bq.delete();
      for (int i = 0; i < k; i++) bq.push_back(rand_beat());
      run_tile(bq, p, $urandom_range(0, 3), r[0]);
    end

    // Reset while draining.
    bq.delete();
    bq.push_back(rand_beat());
    bq.push_back(rand_beat());
    base = ov_cnt;
    push_expected(bq);
    feed_beat(bq[0]);
    feed_beat(bq[1]);
    issue_start(2);
    guard = 0;
    while (ov_cnt - base < 3 && guard < 100) begin
      @(negedge clk);
      #1 guard++;
    end
    chk("reached_drain", ov_cnt - base, 3);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_data", out_data, '0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("abort_no_done", done, 1'b0);
    end
    chk("abort_in_ready_back", in_ready, 1'b1);
    bq.delete();
    bq.push_back(rand_beat());
    run_tile(bq, 1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
